// File: rtl/ghost_motion.sv
// Per-ghost position / direction / mode / frill-animation sequencer feeding the sprite renderer.
// Define GHOST_TUNNEL_WRAP_EN to make horizontal steps past either x edge wrap to the opposite edge.
module ghost_motion #(
  parameter logic [9:0] START_X     = 10'd320,
  parameter logic [9:0] START_Y     = 10'd240,
  parameter logic [9:0] HOME_X      = 10'd320,
  parameter logic [9:0] HOME_Y      = 10'd200,
  parameter logic [9:0] X_MAX       = 10'd632,
  parameter logic [9:0] Y_MAX       = 10'd472,
  parameter int         STEP        = 1,
  parameter int         DEAD_STEP   = 2,
  parameter int         ANIM_FRAMES = 8,
  parameter int         FRGT_FRAMES = 360,
  parameter int         SCOR_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] req_dir,
  input  logic       move_en,
  input  logic       power_pellet,
  input  logic       ghost_eaten,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [1:0] ghost_dir,
  output logic [1:0] ghost_mode,
  output logic       animation_cycle,
  output logic [8:0] mode_timer
);
  localparam logic [9:0] MIN  = 10'd7;
  localparam logic [9:0] STP  = 10'(STEP);
  localparam logic [9:0] DSTP = 10'(DEAD_STEP);
  localparam int         AW   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [1:0] RT = 2'b00, UP = 2'b01, DN = 2'b10, LT = 2'b11;
`ifdef GHOST_TUNNEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {NORM = 2'b00, FRGT = 2'b01, SCOR = 2'b10, DEAD = 2'b11} mode_t;

  mode_t         mode;
  logic [AW-1:0] anim_cnt;
  logic [9:0]    mv_x, mv_y, dd_x, dd_y;
  logic [1:0]    dd_dir;
  logic          arrive;

  assign ghost_mode = mode;

  // Player-style step: clamp to the legal box, except the optional x tunnel.
  always_comb begin
    mv_x = xloc;
    mv_y = yloc;
    unique case (req_dir)
      RT: if (xloc > X_MAX - STP) mv_x = (WRAP && xloc == X_MAX) ? MIN : X_MAX;
          else                    mv_x = xloc + STP;
      LT: if (xloc < MIN + STP)   mv_x = (WRAP && xloc == MIN) ? X_MAX : MIN;
          else                    mv_x = xloc - STP;
      DN: mv_y = (yloc > Y_MAX - STP) ? Y_MAX : yloc + STP;
      UP: mv_y = (yloc < MIN + STP)   ? MIN   : yloc - STP;
    endcase
  end

  // Eyes-home seek: x first, then y, snapping when closer than one step.
  always_comb begin
    dd_x   = xloc;
    dd_y   = yloc;
    dd_dir = ghost_dir;
    if (xloc != HOME_X) begin
      if (xloc < HOME_X) begin
        dd_dir = RT;
        dd_x   = (HOME_X - xloc < DSTP) ? HOME_X : xloc + DSTP;
      end else begin
        dd_dir = LT;
        dd_x   = (xloc - HOME_X < DSTP) ? HOME_X : xloc - DSTP;
      end
    end else if (yloc != HOME_Y) begin
      if (yloc < HOME_Y) begin
        dd_dir = DN;
        dd_y   = (HOME_Y - yloc < DSTP) ? HOME_Y : yloc + DSTP;
      end else begin
        dd_dir = UP;
        dd_y   = (yloc - HOME_Y < DSTP) ? HOME_Y : yloc - DSTP;
      end
    end
    arrive = (dd_x == HOME_X) && (dd_y == HOME_Y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xloc            <= START_X;
      yloc            <= START_Y;
      ghost_dir       <= RT;
      mode            <= NORM;
      animation_cycle <= 1'b0;
      mode_timer      <= 9'd0;
      anim_cnt        <= '0;
    end else begin
      if (frame_tick) begin
        if (anim_cnt == AW'(ANIM_FRAMES - 1)) begin
          anim_cnt        <= '0;
          animation_cycle <= ~animation_cycle;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
        unique case (mode)
          NORM, FRGT: if (move_en) begin
            xloc      <= mv_x;
            yloc      <= mv_y;
            ghost_dir <= req_dir;
          end
          DEAD: begin
            xloc      <= dd_x;
            yloc      <= dd_y;
            ghost_dir <= dd_dir;
          end
          default: ;
        endcase
      end

      // Event loads take priority over the per-tick countdown.
      unique case (mode)
        NORM: if (power_pellet) begin
          mode       <= FRGT;
          mode_timer <= 9'(FRGT_FRAMES);
        end
        FRGT: begin
          if (ghost_eaten) begin
            mode       <= SCOR;
            mode_timer <= 9'(SCOR_FRAMES);
          end else if (power_pellet) begin
            mode_timer <= 9'(FRGT_FRAMES);
          end else if (frame_tick) begin
            if (mode_timer == 9'd1) begin
              mode       <= NORM;
              mode_timer <= 9'd0;
            end else begin
              mode_timer <= mode_timer - 9'd1;
            end
          end
        end
        SCOR: if (frame_tick) begin
          if (mode_timer == 9'd1) begin
            mode       <= DEAD;
            mode_timer <= 9'd0;
          end else begin
            mode_timer <= mode_timer - 9'd1;
          end
        end
        DEAD: if (frame_tick && arrive) mode <= NORM;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ghost_motion.sv
// Directed bench for ghost_motion: reset, animation, steering, mode timers, dead seek, edge clamp.
module tb_ghost_motion;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] req_dir = 2'b00;
  logic       move_en = 1'b0;
  logic       power_pellet = 1'b0;
  logic       ghost_eaten = 1'b0;
  logic [9:0] xloc, yloc;
  logic [1:0] ghost_dir, ghost_mode;
  logic       animation_cycle;
  logic [8:0] mode_timer;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RT = 2'b00, UP = 2'b01, DN = 2'b10, LT = 2'b11;
  localparam logic [1:0] NORM = 2'b00, FRGT = 2'b01, SCOR = 2'b10, DEAD = 2'b11;

  ghost_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .req_dir(req_dir),
    .move_en(move_en), .power_pellet(power_pellet), .ghost_eaten(ghost_eaten),
    .xloc(xloc), .yloc(yloc), .ghost_dir(ghost_dir), .ghost_mode(ghost_mode),
    .animation_cycle(animation_cycle), .mode_timer(mode_timer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse of the chosen inputs; outputs are sampled on the following negedge.
  task automatic pulse(input logic tk, input logic pp, input logic ge);
    @(negedge clk);
    frame_tick = tk; power_pellet = pp; ghost_eaten = ge;
    @(negedge clk);
    frame_tick = 1'b0; power_pellet = 1'b0; ghost_eaten = 1'b0;
  endtask

  // Frame ticks spaced 10 clk apart.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic chk_pos(input string tag, input logic [9:0] x, input logic [9:0] y);
    chk({tag, ".x"}, 32'(xloc), 32'(x));
    chk({tag, ".y"}, 32'(yloc), 32'(y));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_pos("rst", 10'd320, 10'd240);
    chk("rst.dir", 32'(ghost_dir), 32'(RT));
    chk("rst.mode", 32'(ghost_mode), 32'(NORM));
    chk("rst.anim", 32'(animation_cycle), 0);
    chk("rst.timer", 32'(mode_timer), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Animation toggles every 8 ticks.
    ticks(7);
    chk("anim7", 32'(animation_cycle), 0);
    ticks(1);
    chk("anim8", 32'(animation_cycle), 1);
    ticks(8);
    chk("anim16", 32'(animation_cycle), 0);
    chk_pos("idle", 10'd320, 10'd240);

    // Steering.
    move_en = 1'b1; req_dir = LT;
    ticks(4);
    chk("lt4.x", 32'(xloc), 316);
    chk("lt4.dir", 32'(ghost_dir), 32'(LT));
    req_dir = UP;
    ticks(3);
    chk("up3.y", 32'(yloc), 237);
    chk("up3.dir", 32'(ghost_dir), 32'(UP));
    req_dir = RT; ticks(14);
    req_dir = DN; ticks(3);
    chk_pos("to330", 10'd330, 10'd240);
    chk("dn.dir", 32'(ghost_dir), 32'(DN));
    move_en = 1'b0;

    // Frightened timer.
    pulse(1'b0, 1'b1, 1'b0);
    chk("pp.mode", 32'(ghost_mode), 32'(FRGT));
    chk("pp.timer", 32'(mode_timer), 360);
    ticks(359);
    chk("f359.mode", 32'(ghost_mode), 32'(FRGT));
    chk("f359.timer", 32'(mode_timer), 1);
    ticks(1);
    chk("f360.mode", 32'(ghost_mode), 32'(NORM));
    chk("f360.timer", 32'(mode_timer), 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("eat_norm.mode", 32'(ghost_mode), 32'(NORM));
    pulse(1'b0, 1'b1, 1'b0);
    ticks(260);
    chk("f260.timer", 32'(mode_timer), 100);
    pulse(1'b1, 1'b1, 1'b0);
    chk("repp.timer", 32'(mode_timer), 360);
    chk("repp.mode", 32'(ghost_mode), 32'(FRGT));

    // Eaten beats pellet; score phase freezes position.
    pulse(1'b0, 1'b1, 1'b1);
    chk("eat.mode", 32'(ghost_mode), 32'(SCOR));
    chk("eat.timer", 32'(mode_timer), 60);
    move_en = 1'b1; req_dir = LT;
    ticks(30);
    pulse(1'b0, 1'b1, 1'b1);
    chk("scor_ev.mode", 32'(ghost_mode), 32'(SCOR));
    chk("scor_ev.timer", 32'(mode_timer), 30);
    ticks(29);
    chk("s59.timer", 32'(mode_timer), 1);
    chk("s59.mode", 32'(ghost_mode), 32'(SCOR));
    chk_pos("s59", 10'd330, 10'd240);
    chk("s59.dir", 32'(ghost_dir), 32'(DN));
    ticks(1);
    chk("s60.mode", 32'(ghost_mode), 32'(DEAD));
    chk("s60.timer", 32'(mode_timer), 0);
    chk_pos("s60", 10'd330, 10'd240);

    // Dead seek home: x first by 2, then y.
    ticks(1);
    chk_pos("d1", 10'd328, 10'd240);
    chk("d1.dir", 32'(ghost_dir), 32'(LT));
    pulse(1'b0, 1'b1, 1'b1);
    chk("dead_ev.mode", 32'(ghost_mode), 32'(DEAD));
    chk("dead_ev.timer", 32'(mode_timer), 0);
    ticks(4);
    chk_pos("d5", 10'd320, 10'd240);
    ticks(1);
    chk_pos("d6", 10'd320, 10'd238);
    chk("d6.dir", 32'(ghost_dir), 32'(UP));
    ticks(18);
    chk_pos("d24", 10'd320, 10'd202);
    chk("d24.mode", 32'(ghost_mode), 32'(DEAD));
    ticks(1);
    chk_pos("d25", 10'd320, 10'd200);
    chk("d25.mode", 32'(ghost_mode), 32'(NORM));

    // Left and top edges.
    req_dir = LT;
    ticks(313);
    chk("xmin.x", 32'(xloc), 7);
    req_dir = UP; ticks(1);
    req_dir = LT; ticks(1);
`ifdef GHOST_TUNNEL_WRAP_EN
    chk("xedge.x", 32'(xloc), 632);
`else
    chk("xedge.x", 32'(xloc), 7);
`endif
    chk("xedge.dir", 32'(ghost_dir), 32'(LT));
    req_dir = UP;
    ticks(192);
    chk("ymin.y", 32'(yloc), 7);
    req_dir = RT; ticks(1);
    req_dir = UP; ticks(1);
    chk("yedge.y", 32'(yloc), 7);
    chk("yedge.dir", 32'(ghost_dir), 32'(UP));
    move_en = 1'b0;

    // Reset in the middle of frightened mode.
    pulse(1'b0, 1'b1, 1'b0);
    chk("pre_rst.mode", 32'(ghost_mode), 32'(FRGT));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.mode", 32'(ghost_mode), 32'(NORM));
    chk("mid_rst.timer", 32'(mode_timer), 0);
    chk_pos("mid_rst", 10'd320, 10'd240);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    chk("post_rst.mode", 32'(ghost_mode), 32'(NORM));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
